// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b memory path: word/mask types, the request
// record that the arbiter captures on a grant, and the arbiter FSM states.
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } lc3b_arb_state;

  // Which requester was granted most recently; used to break ties.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } lc3b_arb_port;

  // Registered copy of one requester's transaction. read and write are
  // mutually exclusive once captured (write wins for port B).
  typedef struct packed {
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
    logic          read;
    logic          write;
  } lc3b_mem_req;

  localparam lc3b_mem_req MEM_REQ_NONE = '0;

  // Port B issues a write whenever mem_write_b is high, even if mem_read_b
  // is also high; it only reads when the write strobe is low.
  function automatic lc3b_mem_req make_req_b(input lc3b_word      address,
                                             input lc3b_word      wdata,
                                             input lc3b_mem_wmask wmask,
                                             input logic          read,
                                             input logic          write);
    lc3b_mem_req r;
    r.address = address;
    r.wdata   = wdata;
    r.wmask   = wmask;
    r.write   = write;
    r.read    = read & ~write;
    return r;
  endfunction

  // Port A is fetch only: always a read, no write data.
  function automatic lc3b_mem_req make_req_a(input lc3b_word address);
    lc3b_mem_req r;
    r         = MEM_REQ_NONE;
    r.address = address;
    r.read    = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports (A: instruction fetch, B: data) and the
// single physical memory port that the arbiter shares between them.
//
// slave  : arbiter view  - takes requests, returns responses, drives pmem_*
// master : environment view (datapath requesters + physical memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  import lc3b_types::*;

  // port A (read only)
  logic          mem_read_a;
  lc3b_word      mem_address_a;
  logic          mem_resp_a;
  lc3b_word      mem_rdata_a;

  // port B (read/write)
  logic          mem_read_b;
  logic          mem_write_b;
  lc3b_mem_wmask mem_wmask_b;
  lc3b_word      mem_address_b;
  lc3b_word      mem_wdata_b;
  logic          mem_resp_b;
  lc3b_word      mem_rdata_b;

  // physical port
  logic          pmem_read;
  logic          pmem_write;
  lc3b_mem_wmask pmem_wmask;
  lc3b_word      pmem_address;
  lc3b_word      pmem_wdata;
  logic          pmem_resp;
  lc3b_word      pmem_rdata;

  modport slave (
    input  mem_read_a, mem_address_a,
    output mem_resp_a, mem_rdata_a,
    input  mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    output mem_resp_b, mem_rdata_b,
    output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output mem_read_a, mem_address_a,
    input  mem_resp_a, mem_rdata_a,
    output mem_read_b, mem_write_b, mem_wmask_b, mem_address_b, mem_wdata_b,
    input  mem_resp_b, mem_rdata_b,
    input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that stops at all-ones instead of wrapping.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset, clears the count
//   inc    in   count one event this cycle
//   count  out  current count (CNT_WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one physical memory port between the fetch port (A, read only) and
// the MEM-stage data port (B, read/write). One transaction at a time; ties
// are broken round-robin. Responses are routed combinationally from
// pmem_resp to the granted requester.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no physical transaction; arbitrate the current requests
//   SERVE_A | pmem_* carries the captured port A read; wait pmem_resp
//   SERVE_B | pmem_* carries the captured port B op;   wait pmem_resp
//
// Ports:
//   clk             in   system clock
//   rst_n           in   synchronous active-low reset
//   bus             --   requester A/B and physical port (slave modport)
//   conflict_count  out  IDLE cycles with both ports requesting (saturating)
//   b_txn_count     out  completed port B transactions (saturating)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [CNT_WIDTH-1:0] conflict_count,
  output logic [CNT_WIDTH-1:0] b_txn_count
);

  lc3b_arb_state state, state_next;
  lc3b_arb_port  last_served;
  lc3b_mem_req   cap_req;

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic conflict;
  logic busy;
  logic resp_a;
  logic resp_b;

  // -------------------------------------------------------------------------
  // Next-state / grant decode
  // -------------------------------------------------------------------------
  always_comb begin
    req_a      = bus.mem_read_a;
    req_b      = bus.mem_read_b | bus.mem_write_b;
    conflict   = (state == IDLE) && req_a && req_b;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state;

    unique case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (req_b && (!req_a || last_served == PORT_A)) begin
          grant_b    = 1'b1;
          state_next = SERVE_B;
        end else if (req_a) begin
          grant_a    = 1'b1;
          state_next = SERVE_A;
        end
      end
      SERVE_A, SERVE_B: begin
        // Always return to IDLE after a completion: the dead cycle keeps a
        // requester still holding its request in its resp cycle from being
        // granted a second time.
        if (bus.pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, tie-break flag and captured request
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= PORT_A;
      cap_req     <= MEM_REQ_NONE;
    end else begin
      state <= state_next;

      // Requester inputs are only looked at on the grant edge; later
      // changes on them cannot disturb the transaction in flight.
      if (grant_b) begin
        cap_req <= make_req_b(bus.mem_address_b, bus.mem_wdata_b,
                              bus.mem_wmask_b, bus.mem_read_b,
                              bus.mem_write_b);
      end else if (grant_a) begin
        cap_req <= make_req_a(bus.mem_address_a);
      end

      if (resp_a) begin
        last_served <= PORT_A;
      end else if (resp_b) begin
        last_served <= PORT_B;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Physical port: the captured request, or all zero when idle
  // -------------------------------------------------------------------------
  assign busy = (state != IDLE);

  assign bus.pmem_read    = busy & cap_req.read;
  assign bus.pmem_write   = busy & cap_req.write;
  assign bus.pmem_wmask   = busy ? cap_req.wmask   : '0;
  assign bus.pmem_address = busy ? cap_req.address : '0;
  assign bus.pmem_wdata   = busy ? cap_req.wdata   : '0;

  // -------------------------------------------------------------------------
  // Response routing (same cycle as pmem_resp). A pmem_resp in IDLE is
  // dropped because neither serve state is active.
  // -------------------------------------------------------------------------
  assign resp_a = (state == SERVE_A) & bus.pmem_resp;
  assign resp_b = (state == SERVE_B) & bus.pmem_resp;

  assign bus.mem_resp_a  = resp_a;
  assign bus.mem_resp_b  = resp_b;
  assign bus.mem_rdata_a = resp_a ? bus.pmem_rdata : '0;
  assign bus.mem_rdata_b = resp_b ? bus.pmem_rdata : '0;

  // -------------------------------------------------------------------------
  // Arbitration pressure counters
  // -------------------------------------------------------------------------
  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (conflict),
    .count (conflict_count)
  );

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_b_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_b),
    .count (b_txn_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_n2;

  mem_port_arbiter_if bus ();
  mem_port_arbiter_if bus2 ();

  logic [15:0] conflict_count, b_txn_count;
  logic [1:0]  conflict_count2, b_txn_count2;

  mem_port_arbiter #(.CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .conflict_count (conflict_count),
    .b_txn_count    (b_txn_count)
  );

  mem_port_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n2),
    .bus            (bus2.slave),
    .conflict_count (conflict_count2),
    .b_txn_count    (b_txn_count2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- physical memory model ----------------
  logic [15:0] mem [logic [15:0]];
  int          mem_lat = 1;
  int          wcnt    = 0;
  logic        mresp   = 1'b0;
  logic [15:0] mrdata  = 16'h0;
  logic        mresp2  = 1'b0;

  assign bus.pmem_resp   = mresp;
  assign bus.pmem_rdata  = mrdata;
  assign bus2.pmem_resp  = mresp2;
  assign bus2.pmem_rdata = 16'h0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hC3C3;
  endfunction

  always @(posedge clk) begin
    logic [15:0] old;
    #1;
    if (mresp) begin
      mresp  = 1'b0;
      mrdata = 16'h0;
      wcnt   = 0;
    end else if (bus.pmem_read || bus.pmem_write) begin
      wcnt++;
      if (wcnt >= mem_lat) begin
        mresp = 1'b1;
        if (bus.pmem_write) begin
          old = mem_rd(bus.pmem_address);
          mem[bus.pmem_address] = {bus.pmem_wmask[1] ? bus.pmem_wdata[15:8] : old[15:8],
                                   bus.pmem_wmask[0] ? bus.pmem_wdata[7:0]  : old[7:0]};
          mrdata = 16'hD00D;
        end else begin
          mrdata = mem_rd(bus.pmem_address);
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        port;   // 0 = A, 1 = B
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  logic got_a = 1'b0;
  logic got_b = 1'b0;

  function automatic exp_t mk(input logic port, input logic [15:0] addr, input logic wr,
                              input logic [15:0] wdata, input logic [1:0] wmask,
                              input logic [15:0] rdata);
    exp_t e;
    e.port = port; e.addr = addr; e.wr = wr;
    e.wdata = wdata; e.wmask = wmask; e.rdata = rdata;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_resp_a || bus.mem_resp_b) begin
      check("one_resp_only", {31'b0, bus.mem_resp_a & bus.mem_resp_b}, 0);
      check("sb_nonempty_at_resp", {31'b0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_port", {31'b0, bus.mem_resp_b}, {31'b0, e.port});
        check("pmem_addr_at_resp", {16'b0, bus.pmem_address}, {16'b0, e.addr});
        check("pmem_op_at_resp", {30'b0, bus.pmem_read, bus.pmem_write}, {30'b0, !e.wr, e.wr});
        if (e.wr) begin
          check("pmem_wdata_at_resp", {16'b0, bus.pmem_wdata}, {16'b0, e.wdata});
          check("pmem_wmask_at_resp", {30'b0, bus.pmem_wmask}, {30'b0, e.wmask});
        end
        if (bus.mem_resp_b) begin
          check("rdata_b", {16'b0, bus.mem_rdata_b}, {16'b0, e.rdata});
          check("rdata_a_quiet", {16'b0, bus.mem_rdata_a}, 0);
        end else begin
          check("rdata_a", {16'b0, bus.mem_rdata_a}, {16'b0, e.rdata});
          check("rdata_b_quiet", {16'b0, bus.mem_rdata_b}, 0);
        end
      end
      if (bus.mem_resp_a) got_a = 1'b1;
      if (bus.mem_resp_b) got_b = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_b(input logic [15:0] a, input logic rd, input logic wr,
                         input logic [15:0] wd, input logic [1:0] wm);
    bus.mem_address_b = a;
    bus.mem_read_b    = rd;
    bus.mem_write_b   = wr;
    bus.mem_wdata_b   = wd;
    bus.mem_wmask_b   = wm;
  endtask

  task automatic wait_got(input logic port);
    int n = 0;
    while (!(port ? got_b : got_a) && n < 40) begin
      tick();
      n++;
    end
    check(port ? "resp_b_timeout" : "resp_a_timeout", {31'b0, port ? got_b : got_a}, 1);
    got_a = 1'b0;
    got_b = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic single_txn(input logic port, input logic [15:0] addr, input logic rd,
                            input logic wr, input logic [15:0] wd, input logic [1:0] wm,
                            input logic [15:0] exp_rd, input bit chg);
    sb.push_back(mk(port, addr, wr, wd, wm, exp_rd));
    got_a = 1'b0;
    got_b = 1'b0;
    if (port) drive_b(addr, rd, wr, wd, wm);
    else begin
      bus.mem_read_a    = 1'b1;
      bus.mem_address_a = addr;
    end
    @(negedge clk);
    check("pre_grant_idle", {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    @(negedge clk);
    check("grant_op", {30'b0, bus.pmem_read, bus.pmem_write}, {30'b0, rd & ~wr, wr});
    check("grant_addr", {16'b0, bus.pmem_address}, {16'b0, addr});
    if (chg) begin
      tick();
      bus.mem_address_b = 16'hFFFF;
      @(negedge clk);
      check("hold_addr", {16'b0, bus.pmem_address}, {16'b0, addr});
    end
    wait_got(port);
    if (port) drive_b(16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
    else bus.mem_read_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [15:0] a_addr [3];
  logic [15:0] a_exp  [3];
  logic [15:0] b_addr [3];
  logic        b_rd   [3];
  logic        b_wr   [3];
  logic [15:0] b_wd   [3];
  logic [1:0]  b_wm   [3];
  logic [15:0] b_exp  [3];

  initial begin
    int na, nb, n;

    rst_n  = 1'b0;
    rst_n2 = 1'b0;
    bus.mem_read_a    = 1'b0;
    bus.mem_address_a = 16'h0;
    drive_b(16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
    bus2.mem_read_a    = 1'b0;
    bus2.mem_address_a = 16'h0;
    bus2.mem_read_b    = 1'b0;
    bus2.mem_write_b   = 1'b0;
    bus2.mem_wmask_b   = 2'b00;
    bus2.mem_address_b = 16'h0;
    bus2.mem_wdata_b   = 16'h0;
    mem[16'h1234] = 16'hBEEF;
    mem[16'h0020] = 16'h1111;

    tick(); tick(); tick();
    rst_n = 1'b1;

    // A alone, 2-cycle memory
    mem_lat = 2;
    single_txn(1'b0, 16'h1234, 1'b1, 1'b0, 16'h0, 2'b00, 16'hBEEF, 1'b0);
    check("a_alone_btxn", {16'b0, b_txn_count}, 0);
    check("a_alone_conflict", {16'b0, conflict_count}, 0);

    // B write
    mem_lat = 1;
    single_txn(1'b1, 16'h0040, 1'b0, 1'b1, 16'hA5A5, 2'b01, 16'hD00D, 1'b0);
    check("b_write_btxn", {16'b0, b_txn_count}, 1);

    // B read with address changed mid-transaction
    mem_lat = 3;
    single_txn(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0, 2'b00, 16'hC3D3, 1'b1);
    check("b_chg_btxn", {16'b0, b_txn_count}, 2);

    // Reset held 2 cycles with both requesting, then sustained conflict
    mem_lat = 1;
    a_addr = '{16'h1234, 16'h0500, 16'h0020};
    a_exp  = '{16'hBEEF, 16'hC6C3, 16'hA511};
    b_addr = '{16'h0300, 16'h0020, 16'h0020};
    b_rd   = '{1'b1, 1'b1, 1'b1};
    b_wr   = '{1'b0, 1'b1, 1'b0};
    b_wd   = '{16'h0, 16'hA5A5, 16'h0};
    b_wm   = '{2'b00, 2'b10, 2'b00};
    b_exp  = '{16'hC0C3, 16'hD00D, 16'hA511};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(1'b1, b_addr[i], b_wr[i], b_wd[i], b_wm[i], b_exp[i]));
      sb.push_back(mk(1'b0, a_addr[i], 1'b0, 16'h0, 2'b00, a_exp[i]));
    end
    rst_n = 1'b0;
    bus.mem_read_a    = 1'b1;
    bus.mem_address_a = a_addr[0];
    drive_b(b_addr[0], b_rd[0], b_wr[0], b_wd[0], b_wm[0]);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rst_pmem_op", {30'b0, bus.pmem_read, bus.pmem_write}, 0);
    check("rst_pmem_addr", {16'b0, bus.pmem_address}, 0);
    check("rst_pmem_wdata_wmask", {14'b0, bus.pmem_wdata, bus.pmem_wmask}, 0);
    check("rst_resp", {30'b0, bus.mem_resp_a, bus.mem_resp_b}, 0);
    check("rst_rdata", {bus.mem_rdata_a, bus.mem_rdata_b}, 0);
    check("rst_counters", {b_txn_count, conflict_count}, 0);
    tick();
    rst_n = 1'b1;
    got_a = 1'b0;
    got_b = 1'b0;
    na = 0; nb = 0; n = 0;
    while ((na < 3 || nb < 3) && n < 80) begin
      tick();
      n++;
      if (got_a) begin
        got_a = 1'b0;
        na++;
        if (na < 3) bus.mem_address_a = a_addr[na];
        else bus.mem_read_a = 1'b0;
      end
      if (got_b) begin
        got_b = 1'b0;
        nb++;
        if (nb < 3) drive_b(b_addr[nb], b_rd[nb], b_wr[nb], b_wd[nb], b_wm[nb]);
        else drive_b(16'h0, 1'b0, 1'b0, 16'h0, 2'b00);
      end
    end
    check("conflict_a_done", na, 3);
    check("conflict_b_done", nb, 3);
    tick();
    check("conflict_count", {16'b0, conflict_count}, 5);
    check("conflict_btxn", {16'b0, b_txn_count}, 3);
    check("sb_drained", sb.size(), 0);

    // Reset in the middle of a SERVE_A transaction
    mem_lat = 6;
    bus.mem_read_a    = 1'b1;
    bus.mem_address_a = 16'h0100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pmem_read && n < 5);
    check("midrst_granted", {31'b0, bus.pmem_read}, 1);
    tick();
    rst_n = 1'b0;
    bus.mem_read_a = 1'b0;
    @(negedge clk);
    check("midrst_sync_hold", {31'b0, bus.pmem_read}, 1);
    tick();
    @(negedge clk);
    check("midrst_pmem_read", {31'b0, bus.pmem_read}, 0);
    check("midrst_pmem_addr", {16'b0, bus.pmem_address}, 0);
    check("midrst_counters", {b_txn_count, conflict_count}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    mem_lat = 1;
    single_txn(1'b0, 16'h0100, 1'b1, 1'b0, 16'h0, 2'b00, 16'hC2C3, 1'b0);

    // Saturation with CNT_WIDTH = 2
    rst_n2 = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus2.mem_write_b   = 1'b1;
      bus2.mem_address_b = 16'(i);
      bus2.mem_wdata_b   = 16'h5A00 + 16'(i);
      bus2.mem_wmask_b   = 2'b11;
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus2.pmem_write && n < 10);
      check("sat_grant", {31'b0, bus2.pmem_write}, 1);
      mresp2 = 1'b1;
      @(negedge clk);
      check("sat_resp", {31'b0, bus2.mem_resp_b}, 1);
      tick();
      mresp2 = 1'b0;
      bus2.mem_write_b = 1'b0;
      tick();
      check("sat_btxn", {30'b0, b_txn_count2}, (i + 1 > 3) ? 3 : i + 1);
    end
    check("sat_conflict", {30'b0, conflict_count2}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one physical memory port between the pipeline's instruction port (A, fetch, read-only) and data port (B, MEM stage, read/write). It sits between the datapath's two memory interfaces and the single memory or cache port. It serialises one transaction at a time, arbitrates round-robin on conflict and routes the response to the granted requester. Two saturating event counters expose arbitration pressure to the bench.

## Interface
Parameters:
- CNT_WIDTH, 16: width of each saturating event counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read_a  in  1  port A read request; held until mem_resp_a.
- mem_address_a  in  16  port A word address (lc3b_word).
- mem_resp_a  out  1  port A done; one-cycle pulse.
- mem_rdata_a  out  16  port A read data; valid only while mem_resp_a=1.
- mem_read_b / mem_write_b  in  1 / 1  port B requests; held until mem_resp_b.
- mem_wmask_b  in  2  byte mask for writes.
- mem_address_b / mem_wdata_b  in  16 / 16  port B address and write data.
- mem_resp_b  out  1  port B done; one-cycle pulse.
- mem_rdata_b  out  16  port B read data; valid only while mem_resp_b=1.
- pmem_read / pmem_write  out  1 / 1  physical request, held until pmem_resp.
- pmem_wmask  out  2  physical byte mask.
- pmem_address / pmem_wdata  out  16 / 16  physical address and write data.
- pmem_resp  in  1  physical completion.
- pmem_rdata  in  16  physical read data.
- conflict_count  out  CNT_WIDTH  number of IDLE cycles with A and B both requesting.
- b_txn_count  out  CNT_WIDTH  number of completed port B transactions.

## Operation
- The FSM has three states: IDLE, SERVE_A and SERVE_B.
- In IDLE:
  - Only A requesting → SERVE_A.
  - Only B requesting (read or write) → SERVE_B.
  - Both requesting → grant the port not served last. The last_served flag resets to A, so B wins the first tie after reset.
  - Neither requesting → stay in IDLE.
- While in SERVE_x:
  - The pmem_* outputs are driven from the registered copies of port x's address, wdata, wmask and op, captured on the grant edge.
  - Changes on the requester inputs mid-transaction are ignored.
- On pmem_resp in SERVE_x:
  - mem_resp_x=1 and mem_rdata_x=pmem_rdata, combinationally in the same cycle.
  - last_served←x; next state IDLE.
- Port B with read and write both high is a write.
- The non-granted port's mem_resp stays 0. Its rdata outputs are 0 whenever its resp is 0.
- A requester that drops its request mid-transaction does not abort it. The arbiter holds pmem_* until pmem_resp. The response pulse is still emitted and is ignored by the requester.
- A pmem_resp seen in IDLE is ignored.
- Counters:
  - Saturate at all-ones; no wrap.
  - conflict_count increments on each IDLE cycle with both ports requesting.
  - b_txn_count increments on each pmem_resp in SERVE_B.
- Reset (rst_n=0 at an edge), including mid-transaction:
  - State→IDLE, last_served→A, counters→0.
  - Any outstanding physical transaction is abandoned.

## Timing
- Reset values of outputs: pmem_read=pmem_write=0, pmem_wmask=0, pmem_address=pmem_wdata=0, mem_resp_a=mem_resp_b=0, both rdata=0, both counters=0.
- Request seen in IDLE at edge N → grant registered → pmem_read/write high from cycle N+1.
- pmem_resp in cycle M → requester resp in cycle M (zero added latency) → IDLE in M+1.
- A pending request seen in IDLE in cycle M+1 asserts pmem in M+2.
- Minimum spacing is one dead IDLE cycle between physical transactions. This prevents re-granting a requester that is still holding its request in its resp cycle.
- With a 1-cycle memory, each transaction takes 3 cycles from request to next IDLE.
- Under sustained conflict, grants alternate strictly A, B, A, B.

## Structure
- Add lc3b_arb_state (enum IDLE, SERVE_A, SERVE_B) to the lc3b_types package. Reuse lc3b_word.
- One sub-module: sat_counter (parameter CNT_WIDTH; ports clk, rst_n, inc, count). It is instantiated twice.
- The grant mux and capture registers stay in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both ports requesting → all pmem_* =0, both resp=0, counters=0. First grant after release goes to B.
- A alone: read at 0x1234 with memory returning 0xBEEF after 2 cycles → pmem_address=0x1234 from N+1, mem_resp_a pulses one cycle with rdata 0xBEEF, mem_resp_b stays 0.
- B write: address 0x0040, wdata 0xA5A5, wmask 2'b01 → pmem_write=1 with those values. mem_resp_b pulses once and b_txn_count=1.
- Sustained conflict: both ports requesting continuously for 6 transactions → grant order B,A,B,A,B,A. conflict_count equals the number of contended IDLE cycles. No double-grant in any resp cycle.
- Input change mid-transaction: change mem_address_b to 0xFFFF after the grant of 0x0010 → pmem_address stays 0x0010 until pmem_resp.
- Reset mid-transaction in SERVE_A, then saturation: rst_n=0 → IDLE and pmem_read=0 next cycle. Then, with CNT_WIDTH=2 and 5 B transactions → b_txn_count=3.
